// File: rtl/group_drain_ctrl.sv
// group_drain_ctrl: drains one group at a time from the SFTM->DPM group FIFO.
// It issues exactly GROUP_ROWS pops and assembles the returned rows into one
// wide word, row 0 at the LSBs. It then offers that word to the DPM.
// It also owns the group credit count that paces the SFTM writer.
//
// Handshake: out_valid rises when a complete group is assembled. It then stays
// high with out_data stable until a cycle where out_valid && out_ready. That
// cycle transfers the group, and out_valid drops on the following cycle.
module group_drain_ctrl #(
    parameter int DATA_W       = 16,
    parameter int GROUP_ROWS   = 4,
    parameter int DEPTH_GROUPS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 group_done,
    input  logic                                 fifo_empty,
    input  logic                                 fifo_error,
    output logic                                 fifo_rd_en,
    input  logic [DATA_W-1:0]                    fifo_rd_data,
    input  logic                                 fifo_rd_data_valid,
    output logic [GROUP_ROWS*DATA_W-1:0]         out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 credit_available,
    output logic [$clog2(DEPTH_GROUPS+1)-1:0]    groups_pending,
    output logic                                 error
);

    localparam int CNT_W = $clog2(DEPTH_GROUPS + 1);
    localparam int ROW_W = $clog2(GROUP_ROWS + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH_GROUPS);
    localparam logic [ROW_W-1:0] ROWS_C     = ROW_W'(GROUP_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW_C = ROW_W'(GROUP_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        COLLECT = 2'd2,
        PRESENT = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [ROW_W-1:0]             issue_cnt_q, issue_cnt_d;
    logic [ROW_W-1:0]             recv_cnt_q, recv_cnt_d;
    logic [CNT_W-1:0]             credits_q, credits_d;
    logic [CNT_W-1:0]             pending_q, pending_d;
    logic [GROUP_ROWS*DATA_W-1:0] out_data_q, out_data_d;
    logic                         error_q, error_d;

    logic rx_accept;
    logic rx_unexpected;
    logic rx_last;
    logic start_group;
    logic credit_underflow;
    logic pending_overflow;

    // State register and all datapath/counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            credits_q   <= DEPTH_C;
            pending_q   <= '0;
            out_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            credits_q   <= credits_d;
            pending_q   <= pending_d;
            out_data_q  <= out_data_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic: one group in flight, walked through read/collect/present.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending_q != '0) state_d = READ;
            READ:    if (fifo_rd_en && (issue_cnt_q == LAST_ROW_C)) state_d = COLLECT;
            COLLECT: if (recv_cnt_d == ROWS_C) state_d = PRESENT;
            PRESENT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop only in READ, never on empty, never past the group size.
    always_comb begin
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            READ:    fifo_rd_en = !fifo_empty && (issue_cnt_q < ROWS_C);
            PRESENT: out_valid  = 1'b1;
            default: ;
        endcase
    end

    // Issue/receive counting and row capture into the assembled word.
    always_comb begin
        issue_cnt_d   = issue_cnt_q;
        recv_cnt_d    = recv_cnt_q;
        out_data_d    = out_data_q;
        rx_accept     = 1'b0;
        rx_unexpected = 1'b0;
        if (state_q == IDLE) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
        end
        if (fifo_rd_en) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (fifo_rd_data_valid) begin
            // Rows are only expected while a group is being read or collected.
            if (((state_q == READ) || (state_q == COLLECT)) && (recv_cnt_q < ROWS_C)) begin
                rx_accept = 1'b1;
                for (int k = 0; k < GROUP_ROWS; k++) begin
                    if (recv_cnt_q == ROW_W'(k)) begin
                        out_data_d[k*DATA_W +: DATA_W] = fifo_rd_data;
                    end
                end
                recv_cnt_d = recv_cnt_q + 1'b1;
            end else begin
                rx_unexpected = 1'b1;
            end
        end
    end

    // Credit and pending bookkeeping plus the sticky error flag.
    always_comb begin
        rx_last          = rx_accept && (recv_cnt_q == LAST_ROW_C);
        start_group      = (state_q == IDLE) && (pending_q != '0);
        credits_d        = credits_q;
        pending_d        = pending_q;
        credit_underflow = 1'b0;
        pending_overflow = 1'b0;

        // A slot is taken by group_done and freed when its last row arrives.
        if (group_done && !rx_last) begin
            if (credits_q == '0) begin
                credit_underflow = 1'b1;
            end else begin
                credits_d = credits_q - 1'b1;
            end
        end else if (rx_last && !group_done) begin
            if (credits_q != DEPTH_C) begin
                credits_d = credits_q + 1'b1;
            end
        end

        // Pending counts groups written but not yet started by the FSM.
        if (group_done && !start_group) begin
            if (pending_q == DEPTH_C) begin
                pending_overflow = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (start_group && !group_done) begin
            pending_d = pending_q - 1'b1;
        end

        error_d = error_q | fifo_error | credit_underflow | pending_overflow | rx_unexpected;
    end

    assign out_data         = out_data_q;
    assign credit_available = (credits_q != '0);
    assign groups_pending   = pending_q;
    assign error            = error_q;

endmodule

// File: tb/tb_group_drain_ctrl.sv
// tb_group_drain_ctrl: directed bench for group_drain_ctrl with a small FIFO
// model, an expected-group queue and a monitor that checks each handshake.
module tb_group_drain_ctrl;

  localparam int DATA_W       = 16;
  localparam int GROUP_ROWS   = 4;
  localparam int DEPTH_GROUPS = 2;
  localparam int OUT_W        = GROUP_ROWS * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                              group_done;
  logic                              fifo_empty;
  logic                              fifo_error;
  logic                              fifo_rd_en;
  logic [DATA_W-1:0]                 fifo_rd_data;
  logic                              fifo_rd_data_valid;
  logic [OUT_W-1:0]                  out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              credit_available;
  logic [$clog2(DEPTH_GROUPS+1)-1:0] groups_pending;
  logic                              error;

  group_drain_ctrl #(
    .DATA_W       (DATA_W),
    .GROUP_ROWS   (GROUP_ROWS),
    .DEPTH_GROUPS (DEPTH_GROUPS)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .group_done         (group_done),
    .fifo_empty         (fifo_empty),
    .fifo_error         (fifo_error),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_data_valid (fifo_rd_data_valid),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .credit_available   (credit_available),
    .groups_pending     (groups_pending),
    .error              (error)
  );

  // ---------------- FIFO model ----------------
  logic [DATA_W-1:0] fifo_mem [256];
  int                wr_ptr = 0;
  int                rd_ptr = 0;
  logic              force_empty;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr             <= wr_ptr;
      fifo_rd_data_valid <= 1'b0;
      fifo_rd_data       <= '0;
    end else begin
      fifo_rd_data_valid <= fifo_rd_en;
      if (fifo_rd_en) begin
        fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] mon_word;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every accepted group is popped from the expected queue.
  always @(negedge clk) begin
    if (rst_n && fifo_rd_en) chk("rd_en on empty", fifo_empty, 1'b0);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail("unexpected group on output");
      end else begin
        mon_word = exp_q.pop_front();
        chk("group data", out_data, mon_word);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_group(input logic [DATA_W-1:0] r0, input logic [DATA_W-1:0] r1,
                            input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] r3,
                            input logic [OUT_W-1:0] word);
    fifo_mem[wr_ptr[7:0]] = r0;
    fifo_mem[8'(wr_ptr + 1)] = r1;
    fifo_mem[8'(wr_ptr + 2)] = r2;
    fifo_mem[8'(wr_ptr + 3)] = r3;
    wr_ptr = wr_ptr + 4;
    exp_q.push_back(word);
  endtask

  // Cycle-by-cycle expectations; bit i of each pattern is cycle i after group_done.
  task automatic watch(input string tag, input int n,
                       input logic [31:0] rd_pat, input logic [31:0] ov_pat,
                       input logic [31:0] pend_pat, input logic [31:0] cr_pat,
                       input logic [31:0] gd_pat, input logic [31:0] stall_pat,
                       input logic [31:0] rdy_pat);
    for (int i = 0; i < n; i++) begin
      group_done  = gd_pat[i];
      force_empty = stall_pat[i];
      out_ready   = rdy_pat[i];
      @(negedge clk);
      chk($sformatf("%s rd_en c%0d", tag, i), fifo_rd_en, rd_pat[i]);
      chk($sformatf("%s out_valid c%0d", tag, i), out_valid, ov_pat[i]);
      chk($sformatf("%s pending c%0d", tag, i), groups_pending, pend_pat[i]);
      chk($sformatf("%s credit c%0d", tag, i), credit_available, cr_pat[i]);
      chk($sformatf("%s error c%0d", tag, i), error, 1'b0);
      if (out_valid && !out_ready) begin
        if (exp_q.size() == 0) fail($sformatf("%s held data with no expected group c%0d", tag, i));
        else chk($sformatf("%s held data c%0d", tag, i), out_data, exp_q[0]);
      end
      step();
    end
    group_done  = 1'b0;
    force_empty = 1'b0;
    out_ready   = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    fail("timeout");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    group_done  = 1'b0;
    fifo_error  = 1'b0;
    out_ready   = 1'b1;
    force_empty = 1'b0;

    @(negedge clk);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 64'h0);
    chk("reset credit", credit_available, 1'b1);
    chk("reset pending", groups_pending, 2'd0);
    chk("reset error", error, 1'b0);
    chk("reset rd_en", fifo_rd_en, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Single group, no stalls.
    load_group(16'h0011, 16'h0022, 16'h0033, 16'h0044, 64'h0044_0033_0022_0011);
    group_done = 1'b1;
    step();
    watch("single", 8, 32'h1E, 32'h40, 32'h1, 32'hFF, 32'h0, 32'h0, 32'hFF);

    // group_done for B lands on A's last-row receive cycle.
    load_group(16'h1111, 16'h2222, 16'h3333, 16'h4444, 64'h4444_3333_2222_1111);
    load_group(16'ha5a5, 16'h5a5a, 16'h0f0f, 16'hf0f0, 64'hf0f0_0f0f_5a5a_a5a5);
    group_done = 1'b1;
    step();
    watch("simul", 15, 32'hF1E, 32'h2040, 32'hC1, 32'h7FFF, 32'h20, 32'h0, 32'h7FFF);

    // Three-cycle empty stall in the middle of READ.
    load_group(16'h0101, 16'h0202, 16'h0303, 16'h0404, 64'h0404_0303_0202_0101);
    group_done = 1'b1;
    step();
    watch("stall", 11, 32'hC6, 32'h200, 32'h1, 32'h7FF, 32'h0, 32'h38, 32'h7FF);

    // DPM backpressure for ten presented cycles with a second group pending.
    load_group(16'hdead, 16'hbeef, 16'hcafe, 16'hf00d, 64'hf00d_cafe_beef_dead);
    load_group(16'h0001, 16'h0002, 16'h0003, 16'h0004, 64'h0004_0003_0002_0001);
    group_done = 1'b1;
    step();
    watch("bp", 25, 32'h3C001E, 32'h81FFC0, 32'h3FFFD, 32'h1FFFFC3, 32'h2, 32'h0, 32'h1FF0000);

    // Credit exhaustion with the FIFO held empty.
    force_empty = 1'b1;
    load_group(16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 64'hdef0_9abc_5678_1234);
    group_done = 1'b1;
    step();
    group_done = 1'b0;
    @(negedge clk);
    chk("exh credit after 1st", credit_available, 1'b1);
    chk("exh pending after 1st", groups_pending, 2'd1);
    step();
    load_group(16'hffff, 16'h0000, 16'hffff, 16'h0000, 64'h0000_ffff_0000_ffff);
    group_done = 1'b1;
    @(negedge clk);
    chk("exh pending in READ", groups_pending, 2'd0);
    step();
    group_done = 1'b0;
    @(negedge clk);
    chk("exh credit after 2nd", credit_available, 1'b0);
    chk("exh pending after 2nd", groups_pending, 2'd1);
    chk("exh error after 2nd", error, 1'b0);
    chk("exh rd_en while empty", fifo_rd_en, 1'b0);
    step();
    group_done = 1'b1;
    @(negedge clk);
    chk("exh error before 3rd", error, 1'b0);
    step();
    group_done = 1'b0;
    @(negedge clk);
    chk("exh credit after 3rd", credit_available, 1'b0);
    chk("exh error after 3rd", error, 1'b1);
    chk("exh pending after 3rd", groups_pending, 2'd2);

    // Let the first group drain into COLLECT, then reset mid-flight.
    step();
    force_empty = 1'b0;
    for (int i = 0; i < GROUP_ROWS; i++) begin
      @(negedge clk);
      chk($sformatf("drain rd_en c%0d", i), fifo_rd_en, 1'b1);
      step();
    end
    @(negedge clk);
    chk("collect rd_en", fifo_rd_en, 1'b0);
    chk("collect out_valid", out_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 1'b0);
    chk("midreset out_data", out_data, 64'h0);
    chk("midreset credit", credit_available, 1'b1);
    chk("midreset pending", groups_pending, 2'd0);
    chk("midreset error", error, 1'b0);
    chk("midreset rd_en", fifo_rd_en, 1'b0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fresh group after reset.
    load_group(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd, 64'hdddd_cccc_bbbb_aaaa);
    group_done = 1'b1;
    step();
    watch("fresh", 8, 32'h1E, 32'h40, 32'h1, 32'hFF, 32'h0, 32'h0, 32'hFF);

    // A single-cycle fifo_error makes error stick.
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    @(negedge clk);
    chk("fifo_error sets error", error, 1'b1);
    step();
    step();
    @(negedge clk);
    chk("error sticky", error, 1'b1);
    step();

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
